// File: rtl/mode_pkg.sv
// Shared definitions for the mode status reporter: status codes, tx FSM states
// and the mode-to-code mapping.
package mode_pkg;

  localparam logic [7:0] CODE_MANUAL  = 8'h00;
  localparam logic [7:0] CODE_AUTO    = 8'hFF;
  localparam logic [7:0] CODE_OFF     = 8'h5A;
  localparam logic [7:0] CODE_ILLEGAL = 8'hEE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // mode is {manual_on, auto_on}
  function automatic logic [7:0] mode_code(input logic [1:0] mode);
    logic [7:0] code;
    case (mode)
      2'b10:   code = CODE_MANUAL;
      2'b01:   code = CODE_AUTO;
      2'b00:   code = CODE_OFF;
      default: code = CODE_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 serializer with a valid/ready byte input; the byte is captured at
// launch so the frame in flight is immune to later input changes.
module uart_tx_core
  import mode_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             uart_tx_n, busy_n;
  logic             bit_done;

  assign bit_done = (cnt == CNT_LAST);
  assign ready    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      uart_tx <= uart_tx_n;
      busy    <= busy_n;
    end
  end

  // Next-state logic; line level and busy are computed one cycle ahead and registered.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    uart_tx_n = uart_tx;
    busy_n    = busy;
    case (state)
      IDLE: begin
        uart_tx_n = 1'b1;
        busy_n    = 1'b0;
        cnt_n     = '0;
        bit_idx_n = '0;
        if (valid) begin
          state_n   = START;
          shreg_n   = data;
          uart_tx_n = 1'b0;
          busy_n    = 1'b1;
        end
      end
      START: begin
        cnt_n = bit_done ? '0 : cnt + 1'b1;
        if (bit_done) begin
          state_n   = DATA;
          uart_tx_n = shreg[0];
        end
      end
      DATA: begin
        cnt_n = bit_done ? '0 : cnt + 1'b1;
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_n   = STOP;
            uart_tx_n = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            uart_tx_n = shreg[1];
          end
        end
      end
      STOP: begin
        cnt_n = bit_done ? '0 : cnt + 1'b1;
        if (bit_done) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        uart_tx_n = 1'b1;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mode_report_tx.sv
// Reports mode-selector changes to the Arduino as one-byte status frames and
// forwards host bytes over the same UART; pending status always wins.
module mode_report_tx
  import mode_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       manual_on,
  input  logic       auto_on,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy
);

  logic [1:0] mode_in_c;
  logic [1:0] mode_q;
  logic       status_pending;
  logic [7:0] status_code;
  logic       core_ready;
  logic       core_valid_c;
  logic [7:0] core_data_c;
  logic       mode_change_c;
  logic       status_launch_c;

  assign mode_in_c       = {manual_on, auto_on};
  assign mode_change_c   = (mode_in_c != mode_q);
  assign status_launch_c = core_ready && status_pending;

  assign core_valid_c = status_pending || tx_valid;
  assign core_data_c  = status_pending ? status_code : tx_data;
  assign tx_ready     = core_ready && !status_pending;

  // A change seen in the same cycle as a launch re-arms the report with the new code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q         <= 2'b00;
      status_pending <= 1'b0;
      status_code    <= '0;
    end else begin
      mode_q <= mode_in_c;
      if (mode_change_c) begin
        status_pending <= 1'b1;
        status_code    <= mode_code(mode_in_c);
      end else if (status_launch_c) begin
        status_pending <= 1'b0;
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (core_data_c),
    .valid  (core_valid_c),
    .ready  (core_ready),
    .uart_tx(uart_tx),
    .busy   (busy)
  );

endmodule

// File: tb/tb_mode_report_tx.sv
// Directed plus randomized bench for mode_report_tx: line waveforms are checked
// cycle by cycle against frames predicted from the mode/host stimulus.
module tb_mode_report_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       manual_on;
  logic       auto_on;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0] cur_mode;
  logic [1:0] last_mode;
  logic [1:0] mseq [3];
  logic [7:0] rbyte;
  int         nchg;
  logic       changed;

  always #5 clk = ~clk;

  mode_report_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .manual_on(manual_on),
    .auto_on  (auto_on),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_tx  (uart_tx),
    .busy     (busy)
  );

  function automatic logic [7:0] ref_code(input logic [1:0] m);
    case (m)
      2'b10:   return 8'h00;
      2'b01:   return 8'hFF;
      2'b00:   return 8'h5A;
      default: return 8'hEE;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    {manual_on, auto_on} = m;
  endtask

  // Waits for a start bit, then checks every cycle of the 10-bit frame and the idle gap.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [9:0] pat;
    logic       started;
    logic       ok;
    pat     = {1'b1, b, 1'b0};
    started = 1'b0;
    for (int w = 0; w < 300 && !started; w++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) started = 1'b1;
    end
    check({tag, "_start"}, 32'(started), 32'd1);
    if (started) begin
      for (int k = 0; k < 10; k++) begin
        ok = 1'b1;
        for (int c = 0; c < int'(CPB); c++) begin
          if (!(k == 0 && c == 0)) @(negedge clk);
          if (uart_tx !== pat[k] || busy !== 1'b1 || tx_ready !== 1'b0) ok = 1'b0;
        end
        check($sformatf("%s_bit%0d", tag, k), 32'(ok), 32'd1);
      end
      @(negedge clk);
      check({tag, "_gap"}, 32'({busy, uart_tx}), 32'b01);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) ok = 1'b0;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_host(input logic [7:0] b, input string tag);
    logic acc;
    tx_data  = b;
    tx_valid = 1'b1;
    acc      = 1'b0;
    for (int w = 0; w < 300 && !acc; w++) begin
      if (tx_ready === 1'b1) begin
        acc = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    check({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    set_mode(2'b00);
    repeat (3) @(negedge clk);
    check("reset_state", 32'({uart_tx, busy, tx_ready}), 32'b101);
    rst_n = 1'b1;

    quiet(40, "idle_mode00");

    send_host(8'hA5, "host_a5");
    expect_frame(8'hA5, "host_a5");

    set_mode(2'b10);
    expect_frame(8'h00, "manual");
    quiet(20, "after_manual");
    set_mode(2'b01);
    expect_frame(8'hFF, "auto");
    quiet(20, "after_auto");

    // Back-to-back changes: the second arrives on the launch cycle of the first.
    set_mode(2'b00);
    @(negedge clk);
    set_mode(2'b11);
    expect_frame(8'h5A, "off");
    expect_frame(8'hEE, "illegal");
    quiet(20, "after_illegal");

    // Status detected and host byte offered in the same idle cycle.
    set_mode(2'b10);
    @(negedge clk);
    check("ready_blocked", 32'(tx_ready), 32'd0);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    expect_frame(8'h00, "status_first");
    check("host_after_stop", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    expect_frame(8'h3C, "host_3c");
    quiet(20, "after_3c");

    // Mode toggles away and back during a host frame: one report of the final code.
    rbyte = 8'($urandom);
    send_host(rbyte, "host_toggle");
    fork
      expect_frame(rbyte, "host_toggle");
      begin
        repeat (6) @(negedge clk);
        set_mode(2'b01);
        repeat (8) @(negedge clk);
        set_mode(2'b10);
      end
    join
    expect_frame(ref_code(2'b10), "toggle_report");
    quiet(20, "after_toggle");
    cur_mode = 2'b10;

    // Random host bytes with random mode activity during each frame.
    for (int it = 0; it < 8; it++) begin
      rbyte = 8'($urandom);
      nchg  = int'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) mseq[i] = 2'($urandom_range(0, 3));
      changed   = 1'b0;
      last_mode = cur_mode;
      for (int i = 0; i < nchg; i++) begin
        if (mseq[i] != last_mode) changed = 1'b1;
        last_mode = mseq[i];
      end
      send_host(rbyte, $sformatf("rnd%0d", it));
      fork
        expect_frame(rbyte, $sformatf("rnd%0d_host", it));
        begin
          for (int i = 0; i < nchg; i++) begin
            repeat (2 + $urandom_range(0, 7)) @(negedge clk);
            set_mode(mseq[i]);
          end
        end
      join
      if (changed) expect_frame(ref_code(last_mode), $sformatf("rnd%0d_status", it));
      quiet(12, $sformatf("rnd%0d_quiet", it));
      cur_mode = last_mode;
    end

    if (cur_mode != 2'b00) begin
      set_mode(2'b00);
      expect_frame(8'h5A, "to_off");
      quiet(10, "to_off_quiet");
    end

    // One-cycle reset in the middle of the data bits.
    send_host(8'h96, "host_abort");
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_reset", 32'({uart_tx, busy, tx_ready}), 32'b101);
    quiet(60, "abort_no_resend");

    set_mode(2'b01);
    expect_frame(8'hFF, "post_reset_report");
    quiet(60, "post_reset_single");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_report_tx.md
MODE_REPORT_TX -- requirements
Module: mode_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port manual_on  input  1  Manual mode active, from mode selector.
REQ-005 SHALL have port auto_on  input  1  Auto mode active, from mode selector.
REQ-006 SHALL have port tx_data  input  8  host byte to send to Arduino.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid; held until accepted.
REQ-008 SHALL have port tx_ready  output  1  host byte accepted when tx_valid && tx_ready.
REQ-009 SHALL have port uart_tx  output  1  serial line to Arduino RX; idle high.
REQ-010 SHALL have port busy  output  1  a frame is on the line.

Function
REQ-011 SHALL send UART 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP: IDLE->START on frame launch; START->DATA after one bit time; DATA->STOP after bit 7; STOP->IDLE after one bit time.
REQ-013 SHALL drive uart_tx low on the cycle after launch; total frame is 10*CLKS_PER_BIT cycles.
REQ-014 SHALL assert busy in START, DATA and STOP only.
REQ-015 SHALL map mode {manual_on,auto_on} to a status code: 10->0x00, 01->0xFF, 00->0x5A, 11->0xEE (illegal).
REQ-016 SHALL register {manual_on,auto_on} every cycle. A registered value differing from the previous one SHALL set status_pending and latch the new code.
REQ-017 A mode change while status_pending is set and its frame is not yet launched SHALL overwrite the latched code (latest wins, one report).
REQ-018 A mode change during a frame SHALL set status_pending for a report after that frame. It SHALL NOT corrupt the frame in flight.
REQ-019 tx_ready SHALL equal (state==IDLE && !status_pending).
REQ-020 In IDLE, a pending status SHALL launch before any host byte. A simultaneous tx_valid SHALL wait.
REQ-021 Launching a status frame SHALL clear status_pending in the same cycle, unless a new change arrives that cycle, which re-sets it.
REQ-022 The serializer SHALL latch the byte at launch. Later changes to tx_data or the mode code SHALL NOT affect the frame.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap. Its width SHALL be $clog2(CLKS_PER_BIT). The bit index SHALL be 3 bits.
REQ-024 SHALL return to IDLE on the last STOP cycle, giving at least one idle-high cycle between back-to-back frames.

Reset
REQ-025 While rst_n is low at a clk edge, SHALL set: state IDLE, uart_tx 1, busy 0, status_pending 0, counters 0, previous mode register 00.
REQ-026 Reset mid-frame SHALL abort the frame. uart_tx SHALL be high from the next edge. The aborted byte SHALL NOT be resent.
REQ-027 After reset, the first non-00 mode value SHALL produce exactly one status report.

Structure
REQ-028 Package mode_pkg SHALL hold the status codes (0x00, 0xFF, 0x5A, 0xEE) and the tx state enum typedef.
REQ-029 Serialization (FSM, baud counter, shift register) SHALL live in sub-module uart_tx_core with a valid/ready byte input. Mode detection and arbitration SHALL stay in mode_report_tx.

Verification (CLKS_PER_BIT=4)
REQ-030 Reset, then mode 00 for 40 cycles -> uart_tx=1, busy=0, tx_ready=1 throughout; no frame.
REQ-031 tx_data=0xA5 with tx_valid for one cycle -> line 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high 40 cycles.
REQ-032 manual_on rises -> single frame 0x00. Then auto_on=1, manual_on=0 -> single frame 0xFF.
REQ-033 Mode change and tx_valid (0x3C) in the same idle cycle -> tx_ready=0; status frame first; 0x3C accepted after STOP.
REQ-034 Mode toggles 10->01->10 during a host frame -> exactly one status frame (0x00) after it.
REQ-035 rst_n low for 1 cycle mid-DATA -> uart_tx=1, busy=0 next cycle; no completion of the aborted frame.
